// File: rtl/pisa_mem_pkg.sv
// rtl/pisa_mem_pkg.sv - size codes, LSU state enum and size normalisation helper
package pisa_mem_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACCESS  = 2'b01,
        CAPTURE = 2'b10,
        RESP    = 2'b11
    } lsu_state_t;

    // Size code 11 behaves as a word everywhere downstream.
    function automatic logic [1:0] normalize_size(input logic [1:0] size);
        return (size == 2'b11) ? MEM_WORD : size;
    endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - combinational sign/zero extension of LSB-aligned load data
module load_extend
    import pisa_mem_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] result
);

    always_comb begin
        result = data;
        case (size)
            MEM_BYTE: result = {{24{sign_ext & data[7]}}, data[7:0]};
            MEM_HALF: result = {{16{sign_ext & data[15]}}, data[15:0]};
            default:  result = data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit for a byte-lane memory
module load_store_unit
    import pisa_mem_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [31:0] memory_address,
    output logic [31:0] memory_in,
    output logic [1:0]  memory_size,
    output logic        memory_write_enable,
    input  logic [31:0] memory_out
);

    localparam logic [1:0] CAP_LAST = 2'(READ_LATENCY - 1);

    lsu_state_t  state;
    logic [1:0]  cap_cnt;
    logic        write_q;
    logic        signed_q;
    logic [31:0] extended;

    load_extend u_load_extend (
        .data     (memory_out),
        .size     (memory_size),
        .sign_ext (signed_q),
        .result   (extended)
    );

    // memory_* are loaded at accept so they are already valid in the ACCESS cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            cap_cnt             <= 2'd0;
            write_q             <= 1'b0;
            signed_q            <= 1'b0;
            req_ready           <= 1'b1;
            resp_valid          <= 1'b0;
            resp_rdata          <= 32'd0;
            memory_address      <= 32'd0;
            memory_in           <= 32'd0;
            memory_size         <= 2'd0;
            memory_write_enable <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        memory_address      <= req_addr;
                        memory_in           <= req_wdata;
                        memory_size         <= normalize_size(req_size);
                        memory_write_enable <= req_write;
                        write_q             <= req_write;
                        signed_q            <= req_signed;
                        req_ready           <= 1'b0;
                        state               <= ACCESS;
                    end
                end
                ACCESS: begin
                    memory_write_enable <= 1'b0;
                    cap_cnt             <= 2'd0;
                    if (write_q) begin
                        resp_rdata <= 32'd0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (cap_cnt == CAP_LAST) begin
                        cap_cnt    <= 2'd0;
                        resp_rdata <= extended;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cap_cnt <= cap_cnt + 2'd1;
                    end
                end
                RESP: begin
                    // req_ready rises only after this edge, so the exit cycle accepts nothing.
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized bench for two LSU instances (READ_LATENCY 1 and 2)
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_mem = 1'b1;

    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [1:0]  req_write = '0;
    logic [1:0]  req_signed = '0;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready = '0;
    logic [1:0]  memory_write_enable;
    logic [1:0]  req_size [2];
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic [31:0] resp_rdata [2];
    logic [31:0] memory_address [2];
    logic [31:0] memory_in [2];
    logic [1:0]  memory_size [2];
    logic [31:0] memory_out [2];

    logic [7:0]  ref_mem [2][1024];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [7:0]  mem [0:1023];
        logic [31:0] pipe [0:3];

        load_store_unit #(.READ_LATENCY(g + 1)) u_dut (
            .clk                 (clk),
            .rst                 (rst),
            .req_valid           (req_valid[g]),
            .req_ready           (req_ready[g]),
            .req_write           (req_write[g]),
            .req_size            (req_size[g]),
            .req_signed          (req_signed[g]),
            .req_addr            (req_addr[g]),
            .req_wdata           (req_wdata[g]),
            .resp_valid          (resp_valid[g]),
            .resp_ready          (resp_ready[g]),
            .resp_rdata          (resp_rdata[g]),
            .memory_address      (memory_address[g]),
            .memory_in           (memory_in[g]),
            .memory_size         (memory_size[g]),
            .memory_write_enable (memory_write_enable[g]),
            .memory_out          (memory_out[g])
        );

        assign memory_out[g] = pipe[g];

        always @(posedge clk) begin
            if (init_mem) begin
                for (int i = 0; i < 1024; i++) mem[i] <= 8'(i * 37 + 5 + g * 101);
            end else if (memory_write_enable[g]) begin
                mem[10'(memory_address[g])] <= memory_in[g][7:0];
                if (memory_size[g] != 2'b00)
                    mem[10'(memory_address[g] + 32'd1)] <= memory_in[g][15:8];
                if (memory_size[g] == 2'b10) begin
                    mem[10'(memory_address[g] + 32'd2)] <= memory_in[g][23:16];
                    mem[10'(memory_address[g] + 32'd3)] <= memory_in[g][31:24];
                end
            end
            pipe[0] <= {mem[10'(memory_address[g] + 32'd3)], mem[10'(memory_address[g] + 32'd2)],
                        mem[10'(memory_address[g] + 32'd1)], mem[10'(memory_address[g])]};
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k - 1];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] exp_load(input int d, input logic [1:0] sz, input bit sg,
                                             input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[d][(a + 32'(i)) & 32'h3FF];
        if (sz == 2'b00) return {{24{sg & w[7]}}, w[7:0]};
        if (sz == 2'b01) return {{16{sg & w[15]}}, w[15:0]};
        return w;
    endfunction

    task automatic ref_store(input int d, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd);
        for (int i = 0; i < size_bytes(sz); i++) ref_mem[d][(a + 32'(i)) & 32'h3FF] = wd[8*i +: 8];
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic xact(input int d, input bit wr, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        output logic [31:0] rd);
        int n;
        int lat;
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_size[d] = sz;
        req_signed[d] = sg;
        req_addr[d] = a;
        req_wdata[d] = wd;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check_eq("req_ready_timeout", 32'(req_ready[d]), 32'd1);
            req_valid[d] = 1'b0;
            rd = 32'd0;
            return;
        end
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            check_eq("mem_addr", memory_address[d], a);
            check_eq("mem_we", 32'(memory_write_enable[d]), 32'(lat == 1 && wr));
            if (lat == 1) begin
                check_eq("mem_size", 32'(memory_size[d]), (sz == 2'b11) ? 32'd2 : 32'(sz));
                if (wr) check_eq("mem_in", memory_in[d], wd);
            end
        end while (!resp_valid[d] && lat < 20);
        check_eq("latency", 32'(lat), wr ? 32'd2 : 32'(3 + d));
        rd = resp_rdata[d];
        if (wr) check_eq("store_rdata", rd, 32'd0);
        for (int h = 0; h < hold; h++) begin
            req_valid[d] = 1'b1;
            @(negedge clk);
            check_eq("hold_valid", 32'(resp_valid[d]), 32'd1);
            check_eq("hold_rdata", resp_rdata[d], rd);
            check_eq("hold_req_ready", 32'(req_ready[d]), 32'd0);
            check_eq("hold_we", 32'(memory_write_enable[d]), 32'd0);
        end
        resp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[d] = 1'b0;
        req_valid[d] = 1'b0;
        @(negedge clk);
        check_eq("idle_req_ready", 32'(req_ready[d]), 32'd1);
        check_eq("idle_resp_valid", 32'(resp_valid[d]), 32'd0);
    endtask

    task automatic op(input int d, input bit wr, input logic [1:0] sz, input bit sg,
                      input logic [31:0] a, input logic [31:0] wd, input int hold,
                      output logic [31:0] rd);
        logic [31:0] exp;
        exp = exp_load(d, sz, sg, a);
        xact(d, wr, sz, sg, a, wd, hold, rd);
        if (wr) ref_store(d, sz, a, wd);
        else check_eq("load_data", rd, exp);
    endtask

    task automatic check_reset_outputs(input int d);
        check_eq("rst_req_ready", 32'(req_ready[d]), 32'd1);
        check_eq("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
        check_eq("rst_resp_rdata", resp_rdata[d], 32'd0);
        check_eq("rst_mem_addr", memory_address[d], 32'd0);
        check_eq("rst_mem_in", memory_in[d], 32'd0);
        check_eq("rst_mem_size", 32'(memory_size[d]), 32'd0);
        check_eq("rst_mem_we", 32'(memory_write_enable[d]), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int d;
        for (int k = 0; k < 2; k++) begin
            req_size[k] = 2'b00;
            req_addr[k] = 32'd0;
            req_wdata[k] = 32'd0;
            for (int i = 0; i < 1024; i++) ref_mem[k][i] = 8'(i * 37 + 5 + k * 101);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        init_mem = 1'b0;
        check_reset_outputs(0);
        check_reset_outputs(1);

        op(0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 0, rd);
        op(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, rd);
        check_eq("word_deadbeef", rd, 32'hDEADBEEF);

        op(0, 1'b1, 2'b00, 1'b0, 32'h103, 32'h12345680, 0, rd);
        op(0, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 0, rd);
        check_eq("byte_signed", rd, 32'hFFFFFF80);
        op(0, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, rd);
        check_eq("byte_unsigned", rd, 32'h00000080);
        op(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, rd);
        check_eq("byte_neighbours", rd, 32'h80ADBEEF);

        op(0, 1'b1, 2'b01, 1'b0, 32'h1FF, 32'h7777A5C3, 0, rd);
        op(0, 1'b0, 2'b01, 1'b1, 32'h1FF, 32'h0, 0, rd);
        check_eq("half_unaligned", rd, 32'hFFFFA5C3);
        op(0, 1'b0, 2'b10, 1'b0, 32'h1FC, 32'h0, 0, rd);
        check_eq("half_lane_hi", {24'd0, rd[31:24]}, 32'hC3);
        op(0, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 0, rd);
        check_eq("half_lane_lo", {24'd0, rd[7:0]}, 32'hA5);

        op(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5, rd);
        op(0, 1'b1, 2'b11, 1'b0, 32'hFFFFFFFF, 32'hCAFEF00D, 0, rd);
        op(0, 1'b0, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h0, 0, rd);
        check_eq("wrap_word", rd, 32'hCAFEF00D);

        op(1, 1'b1, 2'b10, 1'b0, 32'h140, 32'h89ABCDEF, 0, rd);
        op(1, 1'b0, 2'b01, 1'b1, 32'h141, 32'h0, 2, rd);
        check_eq("lat2_half", rd, 32'hFFFFABCD);

        // Reset while instance 1 sits in CAPTURE.
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_size[1] = 2'b10;
        req_signed[1] = 1'b0;
        req_addr[1] = 32'h140;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs(1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("abandoned_no_resp", 32'(resp_valid[1]), 32'd0);
        end
        op(1, 1'b0, 2'b10, 1'b0, 32'h140, 32'h0, 0, rd);
        check_eq("after_rst_load", rd, 32'h89ABCDEF);

        for (int i = 0; i < 80; i++) begin
            d = int'($urandom_range(0, 1));
            a = ($urandom_range(0, 1) == 0) ? 32'h100 + 32'($urandom_range(0, 32'h2FF)) : $urandom;
            op(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               a, $urandom, int'($urandom_range(0, 2)), rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
